// File: rtl/pcie_dma_cmd_packer_if.sv
// rtl/pcie_dma_cmd_packer_if.sv - host DMA request handshake plus pcie_cmd FIFO write port.
// Slave modport is the packer; master modport is the request source / FIFO side.
interface pcie_dma_cmd_packer_if #(
  parameter int P_SLOT_TAG_WIDTH  = 10,
  parameter int C_PCIE_ADDR_WIDTH = 48
);
  logic                           dma_req_valid;
  logic                           dma_req_ready;
  logic                           dma_req_auto_cpl;
  logic                           dma_req_type;
  logic                           dma_req_dir;
  logic [P_SLOT_TAG_WIDTH-1:0]    dma_req_slot_tag;
  logic [10:0]                    dma_req_4b_len;
  logic [C_PCIE_ADDR_WIDTH-3:0]   dma_req_prp_1;
  logic [C_PCIE_ADDR_WIDTH-3:0]   dma_req_prp_2;
  logic                           dma_req_prp1_list;
  logic                           dma_req_prp2_list;
  logic                           dma_req_prp_split;
  logic                           dma_req_err;
  logic                           pcie_cmd_wr_en;
  logic [C_PCIE_ADDR_WIDTH-3:0]   pcie_cmd_wr_data;
  logic                           pcie_cmd_full_n;

  modport slave (
    input  dma_req_valid, dma_req_auto_cpl, dma_req_type, dma_req_dir,
           dma_req_slot_tag, dma_req_4b_len, dma_req_prp_1, dma_req_prp_2,
           dma_req_prp1_list, dma_req_prp2_list, dma_req_prp_split, pcie_cmd_full_n,
    output dma_req_ready, dma_req_err, pcie_cmd_wr_en, pcie_cmd_wr_data
  );

  modport master (
    output dma_req_valid, dma_req_auto_cpl, dma_req_type, dma_req_dir,
           dma_req_slot_tag, dma_req_4b_len, dma_req_prp_1, dma_req_prp_2,
           dma_req_prp1_list, dma_req_prp2_list, dma_req_prp_split, pcie_cmd_full_n,
    input  dma_req_ready, dma_req_err, pcie_cmd_wr_en, pcie_cmd_wr_data
  );
endinterface

// File: rtl/pcie_dma_cmd_packer.sv
// rtl/pcie_dma_cmd_packer.sv - splits a DMA request at the PRP1 4 KB page and writes a 4-word command.
// Optional PCIE_DMA_CMD_STAT_EN adds request/split counters.
module pcie_dma_cmd_packer #(
  parameter int P_SLOT_TAG_WIDTH  = 10,
  parameter int C_PCIE_ADDR_WIDTH = 48
) (
  input  logic                 pcie_user_clk,
  input  logic                 pcie_user_rst,
`ifdef PCIE_DMA_CMD_STAT_EN
  output logic [31:0]          stat_req_cnt,
  output logic [31:0]          stat_split_cnt,
`endif
  pcie_dma_cmd_packer_if.slave bus
);
  localparam int W = C_PCIE_ADDR_WIDTH - 2;
  localparam int P = P_SLOT_TAG_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_WR0  = 3'd2,
    S_WR1  = 3'd3,
    S_WR2  = 3'd4,
    S_WR3  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic          auto_cpl_q, type_q, dir_q;
  logic [P-1:0]  slot_tag_q;
  logic [10:0]   len_q;
  logic [W-1:0]  prp_1_q;
  logic [W-1:10] prp_2_q;
  logic          prp1_list_q, prp2_list_q, prp_split_q;

  logic [10:0]   room, first_len, second_len;
  logic          second_valid, first_mrd, second_mrd, rcb_cross, len_bad;
  logic [W-1:0]  word0, word1, word2, word3;

  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  // Request is frozen from the handshake until the next return to idle.
  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) begin
      auto_cpl_q  <= 1'b0;
      type_q      <= 1'b0;
      dir_q       <= 1'b0;
      slot_tag_q  <= '0;
      len_q       <= '0;
      prp_1_q     <= '0;
      prp_2_q     <= '0;
      prp1_list_q <= 1'b0;
      prp2_list_q <= 1'b0;
      prp_split_q <= 1'b0;
    end else if (state_q == S_IDLE && bus.dma_req_valid) begin
      auto_cpl_q  <= bus.dma_req_auto_cpl;
      type_q      <= bus.dma_req_type;
      dir_q       <= bus.dma_req_dir;
      slot_tag_q  <= bus.dma_req_slot_tag;
      len_q       <= bus.dma_req_4b_len;
      prp_1_q     <= bus.dma_req_prp_1;
      prp_2_q     <= bus.dma_req_prp_2[W-1:10];
      prp1_list_q <= bus.dma_req_prp1_list;
      prp2_list_q <= bus.dma_req_prp2_list;
      prp_split_q <= bus.dma_req_prp_split;
    end
  end

  // prp_1_q[9:0] is the dword offset within the 4 KB page.
  always_comb begin
    len_bad      = (len_q == 11'd0) || (len_q > 11'd1024);
    room         = 11'd1024 - {1'b0, prp_1_q[9:0]};
    second_valid = len_q > room;
    first_len    = second_valid ? room : len_q;
    second_len   = second_valid ? (len_q - room) : 11'd0;
    first_mrd    = prp1_list_q;
    second_mrd   = second_valid & prp2_list_q;
    rcb_cross    = prp_split_q & first_mrd & second_mrd;

    word0          = '0;
    word0[P+5]     = auto_cpl_q;
    word0[P+4]     = type_q;
    word0[P+3]     = dir_q;
    word0[P+2]     = second_valid;
    word0[P+1]     = first_mrd;
    word0[P]       = second_mrd;
    word0[P-1:0]   = slot_tag_q;

    word1          = '0;
    word1[22]      = rcb_cross;
    word1[21:11]   = first_len;
    word1[10:0]    = second_len;

    word2          = prp_1_q;

    word3          = '0;
    word3[W-1:10]  = prp_2_q;
  end

  always_comb begin
    state_d              = state_q;
    bus.dma_req_ready    = 1'b0;
    bus.dma_req_err      = 1'b0;
    bus.pcie_cmd_wr_en   = 1'b0;
    bus.pcie_cmd_wr_data = '0;
    case (state_q)
      S_IDLE: begin
        bus.dma_req_ready = ~pcie_user_rst;
        if (bus.dma_req_valid) state_d = S_CALC;
      end
      S_CALC: begin
        if (len_bad) begin
          bus.dma_req_err = 1'b1;
          state_d         = S_IDLE;
        end else begin
          state_d = S_WR0;
        end
      end
      S_WR0: begin
        bus.pcie_cmd_wr_data = word0;
        if (bus.pcie_cmd_full_n) begin
          bus.pcie_cmd_wr_en = 1'b1;
          state_d            = S_WR1;
        end
      end
      S_WR1: begin
        bus.pcie_cmd_wr_data = word1;
        if (bus.pcie_cmd_full_n) begin
          bus.pcie_cmd_wr_en = 1'b1;
          state_d            = S_WR2;
        end
      end
      S_WR2: begin
        bus.pcie_cmd_wr_data = word2;
        if (bus.pcie_cmd_full_n) begin
          bus.pcie_cmd_wr_en = 1'b1;
          state_d            = S_WR3;
        end
      end
      S_WR3: begin
        bus.pcie_cmd_wr_data = word3;
        if (bus.pcie_cmd_full_n) begin
          bus.pcie_cmd_wr_en = 1'b1;
          state_d            = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PCIE_DMA_CMD_STAT_EN
  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) begin
      stat_req_cnt   <= '0;
      stat_split_cnt <= '0;
    end else if (state_q == S_WR3 && bus.pcie_cmd_full_n) begin
      stat_req_cnt <= stat_req_cnt + 32'd1;
      if (second_valid) stat_split_cnt <= stat_split_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_dma_cmd_packer.sv
// tb/tb_pcie_dma_cmd_packer.sv - directed self-checking bench for pcie_dma_cmd_packer.
`timescale 1ns/1ps

module tb_pcie_dma_cmd_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pcie_dma_cmd_packer_if #(.P_SLOT_TAG_WIDTH(10), .C_PCIE_ADDR_WIDTH(48)) bus ();

`ifdef PCIE_DMA_CMD_STAT_EN
    logic [31:0] stat_req_cnt, stat_split_cnt;
`endif

    pcie_dma_cmd_packer #(.P_SLOT_TAG_WIDTH(10), .C_PCIE_ADDR_WIDTH(48)) dut (
        .pcie_user_clk (clk),
        .pcie_user_rst (rst),
`ifdef PCIE_DMA_CMD_STAT_EN
        .stat_req_cnt  (stat_req_cnt),
        .stat_split_cnt(stat_split_cnt),
`endif
        .bus           (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $error("FAIL timeout: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic drive_req(input logic ac, input logic ty, input logic dr, input logic [9:0] tag,
                             input logic [10:0] len, input logic [45:0] p1, input logic [45:0] p2,
                             input logic l1, input logic l2, input logic sp);
        @(negedge clk);
        bus.dma_req_auto_cpl  = ac;
        bus.dma_req_type      = ty;
        bus.dma_req_dir       = dr;
        bus.dma_req_slot_tag  = tag;
        bus.dma_req_4b_len    = len;
        bus.dma_req_prp_1     = p1;
        bus.dma_req_prp_2     = p2;
        bus.dma_req_prp1_list = l1;
        bus.dma_req_prp2_list = l2;
        bus.dma_req_prp_split = sp;
        bus.dma_req_valid     = 1'b1;
        @(negedge clk);
        bus.dma_req_valid     = 1'b0;
        bus.dma_req_auto_cpl  = ~ac;
        bus.dma_req_type      = ~ty;
        bus.dma_req_dir       = ~dr;
        bus.dma_req_slot_tag  = ~tag;
        bus.dma_req_4b_len    = ~len;
        bus.dma_req_prp_1     = ~p1;
        bus.dma_req_prp_2     = ~p2;
        bus.dma_req_prp1_list = ~l1;
        bus.dma_req_prp2_list = ~l2;
        bus.dma_req_prp_split = ~sp;
        #1;
    endtask

    task automatic expect_words(input string name, input logic [45:0] w0, input logic [45:0] w1,
                                input logic [45:0] w2, input logic [45:0] w3);
        logic [45:0] exp_w [4];
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk($sformatf("%s_w%0d_en", name, i), bus.pcie_cmd_wr_en, 1'b1);
            chk($sformatf("%s_w%0d_data", name, i), bus.pcie_cmd_wr_data, exp_w[i]);
        end
        @(negedge clk); #1;
        chk($sformatf("%s_ready_back", name), bus.dma_req_ready, 1'b1);
        chk($sformatf("%s_no_extra_wr", name), bus.pcie_cmd_wr_en, 1'b0);
    endtask

    initial begin
        bus.dma_req_valid     = 1'b0;
        bus.dma_req_auto_cpl  = 1'b0;
        bus.dma_req_type      = 1'b0;
        bus.dma_req_dir       = 1'b0;
        bus.dma_req_slot_tag  = '0;
        bus.dma_req_4b_len    = '0;
        bus.dma_req_prp_1     = '0;
        bus.dma_req_prp_2     = '0;
        bus.dma_req_prp1_list = 1'b0;
        bus.dma_req_prp2_list = 1'b0;
        bus.dma_req_prp_split = 1'b0;
        bus.pcie_cmd_full_n   = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", bus.dma_req_ready, 1'b0);
        chk("rst_err", bus.dma_req_err, 1'b0);
        chk("rst_wr_en", bus.pcie_cmd_wr_en, 1'b0);
        chk("rst_wr_data", bus.pcie_cmd_wr_data, 46'h0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_ready", bus.dma_req_ready, 1'b1);

        drive_req(1'b1, 1'b0, 1'b1, 10'h155, 11'h100, 46'h48D17C0, 46'hABCDEF, 1'b0, 1'b0, 1'b0);
        chk("t1_calc_ready", bus.dma_req_ready, 1'b0);
        chk("t1_calc_err", bus.dma_req_err, 1'b0);
        chk("t1_calc_wr_en", bus.pcie_cmd_wr_en, 1'b0);
        expect_words("t1", 46'hB155, 46'h200C0, 46'h48D17C0, 46'hABCC00);
`ifdef PCIE_DMA_CMD_STAT_EN
        chk("t1_stat_req", stat_req_cnt, 32'd1);
        chk("t1_stat_split", stat_split_cnt, 32'd1);
`endif

        drive_req(1'b0, 1'b1, 1'b0, 10'h3FF, 11'h400, 46'h400, 46'h123456789ABF, 1'b0, 1'b1, 1'b0);
        expect_words("t2", 46'h43FF, 46'h200000, 46'h400, 46'h123456789800);

        drive_req(1'b0, 1'b0, 1'b0, 10'h001, 11'd2, 46'h3FF, 46'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk); #1;
        chk("t3_w0_en", bus.pcie_cmd_wr_en, 1'b1);
        chk("t3_w0_data", bus.pcie_cmd_wr_data, 46'h1C01);
        @(negedge clk); bus.pcie_cmd_full_n = 1'b0; #1;
        chk("t3_bp0_en", bus.pcie_cmd_wr_en, 1'b0);
        @(negedge clk); #1;
        chk("t3_bp1_en", bus.pcie_cmd_wr_en, 1'b0);
        @(negedge clk); #1;
        chk("t3_bp2_en", bus.pcie_cmd_wr_en, 1'b0);
        @(negedge clk); bus.pcie_cmd_full_n = 1'b1; #1;
        chk("t3_w1_en", bus.pcie_cmd_wr_en, 1'b1);
        chk("t3_w1_data", bus.pcie_cmd_wr_data, 46'h400801);
        @(negedge clk); #1;
        chk("t3_w2_data", bus.pcie_cmd_wr_data, 46'h3FF);
        chk("t3_w2_en", bus.pcie_cmd_wr_en, 1'b1);
        @(negedge clk); #1;
        chk("t3_w3_data", bus.pcie_cmd_wr_data, 46'h0);
        chk("t3_w3_en", bus.pcie_cmd_wr_en, 1'b1);
        @(negedge clk); #1;
        chk("t3_ready_back", bus.dma_req_ready, 1'b1);
        chk("t3_no_extra_wr", bus.pcie_cmd_wr_en, 1'b0);

        drive_req(1'b0, 1'b0, 1'b0, 10'h2AA, 11'd5, 46'h0, 46'h3FFFFFFFFFFF, 1'b1, 1'b1, 1'b1);
        expect_words("t4", 46'hAAA, 46'h2800, 46'h0, 46'h3FFFFFFFFC00);

        drive_req(1'b1, 1'b1, 1'b1, 10'h0F0, 11'd0, 46'h123, 46'h456, 1'b0, 1'b0, 1'b0);
        chk("len0_err", bus.dma_req_err, 1'b1);
        chk("len0_ready", bus.dma_req_ready, 1'b0);
        chk("len0_wr_en", bus.pcie_cmd_wr_en, 1'b0);
        @(negedge clk); #1;
        chk("len0_err_clear", bus.dma_req_err, 1'b0);
        chk("len0_ready_back", bus.dma_req_ready, 1'b1);
        chk("len0_wr_en2", bus.pcie_cmd_wr_en, 1'b0);
        drive_req(1'b0, 1'b0, 1'b0, 10'h00F, 11'h401, 46'h0, 46'h0, 1'b1, 1'b1, 1'b1);
        chk("len401_err", bus.dma_req_err, 1'b1);
        chk("len401_wr_en", bus.pcie_cmd_wr_en, 1'b0);
        @(negedge clk); #1;
        chk("len401_err_clear", bus.dma_req_err, 1'b0);
        chk("len401_ready_back", bus.dma_req_ready, 1'b1);
        chk("len401_wr_en2", bus.pcie_cmd_wr_en, 1'b0);

        drive_req(1'b1, 1'b0, 1'b1, 10'h155, 11'h100, 46'h48D17C0, 46'hABCDEF, 1'b0, 1'b0, 1'b0);
        expect_words("t5", 46'hB155, 46'h200C0, 46'h48D17C0, 46'hABCC00);
`ifdef PCIE_DMA_CMD_STAT_EN
        chk("t5_stat_req", stat_req_cnt, 32'd5);
        chk("t5_stat_split", stat_split_cnt, 32'd3);
`endif

        drive_req(1'b0, 1'b1, 1'b0, 10'h3FF, 11'h400, 46'h400, 46'h123456789ABF, 1'b0, 1'b1, 1'b0);
        @(negedge clk); #1;
        chk("t6_w0_data", bus.pcie_cmd_wr_data, 46'h43FF);
        @(negedge clk); #1;
        chk("t6_w1_data", bus.pcie_cmd_wr_data, 46'h200000);
        @(negedge clk); rst = 1'b1; #1;
        chk("t6_rst_wr_en", bus.pcie_cmd_wr_en, 1'b0);
        chk("t6_rst_wr_data", bus.pcie_cmd_wr_data, 46'h0);
        chk("t6_rst_ready", bus.dma_req_ready, 1'b0);
        chk("t6_rst_err", bus.dma_req_err, 1'b0);
`ifdef PCIE_DMA_CMD_STAT_EN
        chk("t6_stat_req_clr", stat_req_cnt, 32'd0);
        chk("t6_stat_split_clr", stat_split_cnt, 32'd0);
`endif
        @(negedge clk); rst = 1'b0; #1;
        chk("t6_ready_after", bus.dma_req_ready, 1'b1);
        chk("t6_wr_en_after", bus.pcie_cmd_wr_en, 1'b0);

        drive_req(1'b0, 1'b0, 1'b0, 10'h2AA, 11'd5, 46'h0, 46'h3FFFFFFFFFFF, 1'b1, 1'b1, 1'b1);
        expect_words("t7", 46'hAAA, 46'h2800, 46'h0, 46'h3FFFFFFFFC00);
`ifdef PCIE_DMA_CMD_STAT_EN
        chk("t7_stat_req", stat_req_cnt, 32'd1);
        chk("t7_stat_split", stat_split_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcie_dma_cmd_packer.md
# pcie_dma_cmd_packer

Front end of the PCIe DMA command path. It accepts one host DMA request per handshake, splits the transfer at the 4 KB page boundary of PRP1, and derives the PRP-fetch flags. It then writes the resulting four-word command into the pcie_cmd FIFO, which is drained by the DMA command generator. It is the writer side of that 46-bit, four-word command format.

## Interface
- P_SLOT_TAG_WIDTH, 10, host command slot tag width (must be ≤ 16).
- C_PCIE_ADDR_WIDTH, 48, PCIe address width; command words are C_PCIE_ADDR_WIDTH-2 = 46 bits.
- pcie_user_clk  in  1  sole clock, all logic on rising edge.
- pcie_user_rst  in  1  reset, asynchronous, active-high.
- dma_req_valid  in  1  request valid.
- dma_req_ready  out  1  request ready; handshake completes on valid & ready at a clock edge.
- dma_req_auto_cpl  in  1  auto-completion flag.
- dma_req_type  in  1  DMA command type.
- dma_req_dir  in  1  1 = device-to-host (tx), 0 = host-to-device (rx).
- dma_req_slot_tag  in  P_SLOT_TAG_WIDTH  host command slot tag.
- dma_req_4b_len  in  11  transfer length in dwords; legal range 1..1024 (11'h400 = 4 KB).
- dma_req_prp_1  in  C_PCIE_ADDR_WIDTH-2  PRP1 byte address [47:2].
- dma_req_prp_2  in  C_PCIE_ADDR_WIDTH-2  PRP2 byte address [47:2]; only bits [47:12] are used.
- dma_req_prp1_list  in  1  first-segment PRP must be fetched from a PRP list.
- dma_req_prp2_list  in  1  second-segment PRP must be fetched from a PRP list.
- dma_req_prp_split  in  1  PRP pair straddles two PRP FIFO entries.
- dma_req_err  out  1  one-cycle pulse: the accepted request had an illegal length and was dropped.
- pcie_cmd_wr_en  out  1  FIFO write strobe.
- pcie_cmd_wr_data  out  46  FIFO write data.
- pcie_cmd_full_n  in  1  FIFO not full; a write is legal only while it is high.

## Operation
- States: S_IDLE, S_CALC, S_WR0, S_WR1, S_WR2, S_WR3.
- S_IDLE:
  - dma_req_ready = 1.
  - On handshake, register all request fields and go to S_CALC.
- S_CALC:
  - Check the length. If it is 0 or > 1024, pulse dma_req_err for this cycle and go to S_IDLE; nothing is written.
  - Otherwise compute the split and go to S_WR0.
- Split arithmetic (11-bit unsigned):
  - room = 1024 − prp_1[11:2].
  - 1st_len = min(len, room).
  - 2nd_valid = (len > room).
  - 2nd_len = 2nd_valid ? len − room : 0.
- Derived flags:
  - 1st_mrd = prp1_list.
  - 2nd_mrd = 2nd_valid & prp2_list.
  - rcb_cross = prp_split & 1st_mrd & 2nd_mrd; otherwise forced to 0.
- Word layout (P = P_SLOT_TAG_WIDTH; all unlisted bits are 0):
  - Word0: [P+5] auto_cpl, [P+4] type, [P+3] dir, [P+2] 2nd_valid, [P+1] 1st_mrd, [P] 2nd_mrd, [P-1:0] slot_tag.
  - Word1: [22] rcb_cross, [21:11] 1st_len, [10:0] 2nd_len.
  - Word2: prp_1[47:2] on [45:0].
  - Word3: prp_2[47:12] on [45:10], [9:0] = 0.
- S_WRn (n = 0..3):
  - If pcie_cmd_full_n = 1: pcie_cmd_wr_en = 1, pcie_cmd_wr_data = Word n, then advance (S_WR3 returns to S_IDLE).
  - Else hold the state with wr_en = 0.
  - The FIFO may go full between words; each word waits independently.
- Exactly 4 writes occur per legal request, in order, never interleaved with another request.
- Illegal states decode to S_IDLE.

## Timing
- Reset values: dma_req_ready = 0 during reset, becoming 1 when S_IDLE is entered after release; dma_req_err = 0; pcie_cmd_wr_en = 0; pcie_cmd_wr_data = 0.
- dma_req_ready, pcie_cmd_wr_en and pcie_cmd_wr_data decode combinationally from the state, the registered request and pcie_cmd_full_n. No output depends combinationally on dma_req_valid.
- Handshake at edge T; S_CALC occupies cycle T+1.
- With the FIFO never full, Word0..Word3 are written in cycles T+2..T+5, and ready is high again in cycle T+6. Peak throughput is one request per 6 cycles.
- An illegal request has dma_req_err high in cycle T+1 and ready high again in cycle T+2.
- The registered request is stable from the handshake until the return to S_IDLE; input changes after the handshake have no effect.
- Reset mid-request: immediate return to S_IDLE with outputs at their reset values. Words already written stay in the FIFO; the FIFO and its consumer share this reset.

## Configuration
- PCIE_DMA_CMD_STAT_EN defined: adds two outputs, each a 32-bit wrapping counter cleared by reset.
  - stat_req_cnt: increments once per Word3 write.
  - stat_split_cnt: increments on Word3 writes where 2nd_valid = 1.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Split request: slot_tag 10'h155, dir 1, type 0, auto_cpl 1, prp_1 = 48'h0000_1234_5F00, len 11'h100, no list flags, FIFO always ready → 4 writes in T+2..T+5.
  - Word0 = 46'hB155.
  - Word1 = 46'h200C0 (1st 0x40, 2nd 0xC0).
  - Word2 = 48'h0000_1234_5F00 >> 2.
  - Word3 = {prp_2[47:12], 10'b0}.
- Page-aligned full page: prp_1 = 48'h1000, len 11'h400 → Word1 = 46'h200000, 2nd_valid = 0, 2nd_mrd = 0 even with prp2_list = 1.
- Both list flags set, prp_split = 1, split request → Word0 bits [P+1] and [P] = 1, Word1 bit 22 = 1. With prp_split = 1 but no 2nd segment → bit 22 = 0.
- Back-pressure: pcie_cmd_full_n low for 3 cycles during S_WR1 → wr_en stays 0 for those cycles, Word1 is written once afterwards, with no duplicate or missing word.
- Illegal lengths 0 and 11'h401 → dma_req_err pulses for one cycle, zero FIFO writes, ready back at T+2. A following legal request processes normally.
- Reset asserted during S_WR2 → wr_en = 0 immediately, state S_IDLE after release. With PCIE_DMA_CMD_STAT_EN, counters read 0.
